// File: rtl/soc_bus_arbiter_pkg.sv
// Shared types and defaults for the SOC bus arbiter slice.
package soc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned ADDR_W_DEF   = 24;
  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Watchdog width; kept at one bit when the watchdog is disabled.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/soc_bus_arbiter_if.sv
// One bus segment: request/address/write side plus the ack/rdata/err response.
interface soc_bus_arbiter_if
  import soc_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  logic              err;

  // Side that issues requests.
  modport master (output req, addr, wmask, wdata, input ack, rdata, err);
  // Side that answers requests.
  modport slave  (input req, addr, wmask, wdata, output ack, rdata, err);
endinterface

// File: rtl/soc_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);
  // Combinational winner selection.
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last : req1;
  end
endmodule

// File: rtl/soc_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between fetch (m0) and load/store (m1),
// one transaction at a time, with a watchdog that terminates hung slave accesses.
module soc_bus_arbiter
  import soc_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  soc_bus_arbiter_if.slave        m0,
  soc_bus_arbiter_if.slave        m1,
  soc_bus_arbiter_if.master       s,
  output logic                    grant_id
);

  localparam int unsigned         WDOG_W    = wdog_width(TIMEOUT);
  localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                grant_q, grant_d;
  logic                s_req_q, s_req_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [3:0]          s_wmask_q, s_wmask_d;
  logic [31:0]         s_wdata_q, s_wdata_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic                m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [31:0]         m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic                pick_valid, pick_winner;
  logic                resp_valid, resp_err;
  logic [31:0]         resp_data;
  logic                unused_inputs;

  // m0 is read-only and the slave has no error line of its own.
  assign unused_inputs = ^{m0.wmask, m0.wdata, s.err};

  rr_pick2 u_pick (
    .req0   (m0.req),
    .req1   (m1.req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Next-state and next-output computation; acks default low so they pulse once.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    s_req_d    = s_req_q;
    s_addr_d   = s_addr_q;
    s_wmask_d  = s_wmask_q;
    s_wdata_d  = s_wdata_q;
    wdog_d     = wdog_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d   = ST_BUSY;
          grant_d   = pick_winner;
          last_d    = pick_winner;
          s_req_d   = 1'b1;
          s_addr_d  = pick_winner ? m1.addr  : m0.addr;
          s_wmask_d = pick_winner ? m1.wmask : '0;
          s_wdata_d = pick_winner ? m1.wdata : '0;
          wdog_d    = '0;
        end
      end
      ST_BUSY: begin
        // A slave ack on the timeout cycle takes priority over the watchdog.
        if (s.ack && s_req_q) begin
          resp_valid = 1'b1;
          resp_data  = s.rdata;
        end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
          resp_valid = 1'b1;
          resp_data  = ERR_DATA;
          resp_err   = 1'b1;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (resp_valid) begin
          s_req_d = 1'b0;
          state_d = ST_RESP;
          if (grant_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = resp_data;
            m1_err_d   = resp_err;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = resp_data;
            m0_err_d   = resp_err;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset leaves m0 favoured on the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      grant_q    <= 1'b0;
      s_req_q    <= 1'b0;
      s_addr_q   <= '0;
      s_wmask_q  <= '0;
      s_wdata_q  <= '0;
      wdog_q     <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      s_req_q    <= s_req_d;
      s_addr_q   <= s_addr_d;
      s_wmask_q  <= s_wmask_d;
      s_wdata_q  <= s_wdata_d;
      wdog_q     <= wdog_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s.req    = s_req_q;
  assign s.addr   = s_addr_q;
  assign s.wmask  = s_wmask_q;
  assign s.wdata  = s_wdata_q;
  assign m0.ack   = m0_ack_q;
  assign m0.rdata = m0_rdata_q;
  assign m0.err   = m0_err_q;
  assign m1.ack   = m1_ack_q;
  assign m1.rdata = m1_rdata_q;
  assign m1.err   = m1_err_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter with the watchdog set to 8 cycles.
module tb_soc_bus_arbiter;
  import soc_bus_arbiter_pkg::*;

  logic clk;
  logic resetn;
  logic grant_id;
  int   total;
  int   bad;
  logic [31:0] exp_rd0, exp_rd1;

  soc_bus_arbiter_if #(.ADDR_W(24)) m0_bus ();
  soc_bus_arbiter_if #(.ADDR_W(24)) m1_bus ();
  soc_bus_arbiter_if #(.ADDR_W(24)) s_bus  ();

  soc_bus_arbiter #(.ADDR_W(24), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .s        (s_bus),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  task automatic wait_sreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_bus.req === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Slave acks two cycles after s_req was seen; returns #1 after the master ack edge.
  task automatic respond(input logic [31:0] data);
    @(posedge clk); #1;
    s_bus.ack   = 1'b1;
    s_bus.rdata = data;
    @(posedge clk); #1;
    s_bus.ack   = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    m0_bus.req = 0; m0_bus.addr = '0; m0_bus.wmask = '0; m0_bus.wdata = '0;
    m1_bus.req = 0; m1_bus.addr = '0; m1_bus.wmask = '0; m1_bus.wdata = '0;
    s_bus.ack = 0; s_bus.rdata = '0; s_bus.err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL rst_s_req got=%b exp=0", s_bus.req); end
    total++; if (s_bus.addr !== 24'h0) begin bad++; $display("FAIL rst_s_addr got=%h exp=0", s_bus.addr); end
    total++; if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin bad++; $display("FAIL rst_acks got=%b%b exp=00", m0_bus.ack, m1_bus.ack); end
    total++; if (m0_bus.rdata !== 32'h0 || m1_bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", m0_bus.rdata, m1_bus.rdata); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL rst_grant got=%b exp=0", grant_id); end
    resetn = 1'b1;
    exp_rd0 = '0; exp_rd1 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    bit ok;
    m0_bus.req = 1; m0_bus.addr = 24'h000010; m0_bus.wmask = 4'hf; m0_bus.wdata = 32'h55555555;
    wait_sreq(ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_sreq got=timeout exp=s_req"); end
    total++; if (s_bus.addr !== 24'h000010) begin bad++; $display("FAIL t1_s_addr got=%h exp=000010", s_bus.addr); end
    total++; if (s_bus.wmask !== 4'h0) begin bad++; $display("FAIL t1_s_wmask got=%h exp=0", s_bus.wmask); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL t1_grant got=%b exp=0", grant_id); end
    total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL t1_early_ack got=%b exp=0", m0_bus.ack); end
    respond(32'hCAFEF00D);
    exp_rd0 = 32'hCAFEF00D;
    m0_bus.req = 0;
    total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL t1_ack got=%b exp=1", m0_bus.ack); end
    total++; if (m0_bus.rdata !== exp_rd0) begin bad++; $display("FAIL t1_rdata got=%h exp=%h", m0_bus.rdata, exp_rd0); end
    total++; if (m0_bus.err !== 1'b0 || m1_bus.ack !== 1'b0) begin bad++; $display("FAIL t1_err_m1ack got=%b/%b exp=0/0", m0_bus.err, m1_bus.ack); end
    total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL t1_sreq_drop got=%b exp=0", s_bus.req); end
    @(posedge clk); #1;
    total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL t1_ack_width got=%b exp=0", m0_bus.ack); end
  endtask

  task automatic test_write();
    bit ok;
    m1_bus.req = 1; m1_bus.addr = 24'h400004; m1_bus.wmask = 4'b0011; m1_bus.wdata = 32'h12345678;
    wait_sreq(ok);
    total++; if (!ok) begin bad++; $display("FAIL t3_sreq got=timeout exp=s_req"); end
    total++; if (s_bus.addr !== 24'h400004) begin bad++; $display("FAIL t3_s_addr got=%h exp=400004", s_bus.addr); end
    total++; if (s_bus.wmask !== 4'b0011) begin bad++; $display("FAIL t3_s_wmask got=%h exp=3", s_bus.wmask); end
    total++; if (s_bus.wdata !== 32'h12345678) begin bad++; $display("FAIL t3_s_wdata got=%h exp=12345678", s_bus.wdata); end
    total++; if (grant_id !== 1'b1) begin bad++; $display("FAIL t3_grant got=%b exp=1", grant_id); end
    respond(32'hA5A50003);
    exp_rd1 = 32'hA5A50003;
    m1_bus.req = 0;
    total++; if (m1_bus.ack !== 1'b1 || m1_bus.err !== 1'b0) begin bad++; $display("FAIL t3_ack_err got=%b/%b exp=1/0", m1_bus.ack, m1_bus.err); end
    total++; if (m0_bus.ack !== 1'b0 || m0_bus.rdata !== exp_rd0) begin bad++; $display("FAIL t3_m0_untouched got=%b/%h exp=0/%h", m0_bus.ack, m0_bus.rdata, exp_rd0); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_g[4] = '{0, 1, 0, 1};
    m0_bus.req = 1; m0_bus.addr = 24'h000100; m0_bus.wmask = 4'hf;
    m1_bus.req = 1; m1_bus.addr = 24'h000200; m1_bus.wmask = 4'h0;
    for (int t = 0; t < 4; t++) begin
      logic [31:0] d;
      logic [23:0] ea;
      d  = 32'h10000000 + 32'(t);
      ea = (exp_g[t] == 1) ? 24'h000200 : 24'h000100;
      wait_sreq(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_sreq[%0d] got=timeout exp=s_req", t); end
      total++; if (grant_id !== 1'(exp_g[t])) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%0d", t, grant_id, exp_g[t]); end
      total++; if (s_bus.addr !== ea) begin bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", t, s_bus.addr, ea); end
      respond(d);
      if (exp_g[t] == 0) exp_rd0 = d; else exp_rd1 = d;
      total++;
      if ({m1_bus.ack, m0_bus.ack} !== ((exp_g[t] == 1) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_acks[%0d] got=m1:%b m0:%b exp_master=%0d", t, m1_bus.ack, m0_bus.ack, exp_g[t]);
      end
      total++; if (m0_bus.rdata !== exp_rd0 || m1_bus.rdata !== exp_rd1) begin
        bad++; $display("FAIL rr_rdata[%0d] got=%h/%h exp=%h/%h", t, m0_bus.rdata, m1_bus.rdata, exp_rd0, exp_rd1);
      end
      if (t == 2) m0_bus.req = 0;
      if (t == 3) m1_bus.req = 0;
      @(posedge clk); #1;
      total++; if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin bad++; $display("FAIL rr_ack_width[%0d] got=%b%b exp=00", t, m0_bus.ack, m1_bus.ack); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    m1_bus.req = 1; m1_bus.addr = 24'h000020; m1_bus.wmask = 4'h0;
    wait_sreq(ok);
    total++; if (!ok) begin bad++; $display("FAIL t4_sreq got=timeout exp=s_req"); end
    cnt = 0;
    while (s_bus.req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    total++; if (cnt != 8) begin bad++; $display("FAIL t4_busy_cycles got=%0d exp=8", cnt); end
    total++; if (m1_bus.ack !== 1'b1) begin bad++; $display("FAIL t4_ack got=%b exp=1", m1_bus.ack); end
    total++; if (m1_bus.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL t4_rdata got=%h exp=deadbeef", m1_bus.rdata); end
    total++; if (m1_bus.err !== 1'b1) begin bad++; $display("FAIL t4_err got=%b exp=1", m1_bus.err); end
    exp_rd1 = 32'hDEADBEEF;
    s_bus.ack = 1; s_bus.rdata = 32'h77777777;
    m1_bus.req = 0;
    @(posedge clk); #1;
    total++; if (m1_bus.ack !== 1'b0 || m1_bus.rdata !== 32'hDEADBEEF || m1_bus.err !== 1'b1) begin
      bad++; $display("FAIL t4_late_ack got=%b/%h/%b exp=0/deadbeef/1", m1_bus.ack, m1_bus.rdata, m1_bus.err);
    end
    @(posedge clk); #1;
    total++; if (s_bus.req !== 1'b0 || m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
      bad++; $display("FAIL t4_idle got=%b/%b/%b exp=0/0/0", s_bus.req, m0_bus.ack, m1_bus.ack);
    end
    s_bus.ack = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_ack_on_timeout();
    bit ok;
    m0_bus.req = 1; m0_bus.addr = 24'h000030;
    wait_sreq(ok);
    total++; if (!ok) begin bad++; $display("FAIL t5_sreq got=timeout exp=s_req"); end
    repeat (7) @(posedge clk);
    #1;
    total++; if (s_bus.req !== 1'b1) begin bad++; $display("FAIL t5_sreq_held got=%b exp=1", s_bus.req); end
    s_bus.ack = 1; s_bus.rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    s_bus.ack = 0; m0_bus.req = 0;
    exp_rd0 = 32'h0BADF00D;
    total++; if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0) begin bad++; $display("FAIL t5_ack_err got=%b/%b exp=1/0", m0_bus.ack, m0_bus.err); end
    total++; if (m0_bus.rdata !== exp_rd0) begin bad++; $display("FAIL t5_rdata got=%h exp=%h", m0_bus.rdata, exp_rd0); end
    total++; if (m1_bus.rdata !== 32'hDEADBEEF || m1_bus.err !== 1'b1) begin bad++; $display("FAIL t5_m1_hold got=%h/%b exp=deadbeef/1", m1_bus.rdata, m1_bus.err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    m1_bus.req = 1; m1_bus.addr = 24'h000050;
    wait_sreq(ok);
    total++; if (!ok) begin bad++; $display("FAIL t6_sreq got=timeout exp=s_req"); end
    resetn = 1'b0;
    #1;
    total++; if (s_bus.req !== 1'b0) begin bad++; $display("FAIL t6_async_sreq got=%b exp=0", s_bus.req); end
    total++; if (m1_bus.rdata !== 32'h0 || m1_bus.err !== 1'b0 || m0_bus.rdata !== 32'h0) begin
      bad++; $display("FAIL t6_rst_vals got=%h/%b/%h exp=0/0/0", m1_bus.rdata, m1_bus.err, m0_bus.rdata);
    end
    exp_rd0 = '0; exp_rd1 = '0;
    m1_bus.req = 0;
    @(posedge clk); #1;
    total++; if (m1_bus.ack !== 1'b0 || grant_id !== 1'b0) begin bad++; $display("FAIL t6_no_ack got=%b/%b exp=0/0", m1_bus.ack, grant_id); end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    m0_bus.req = 1; m0_bus.addr = 24'h000060;
    m1_bus.req = 1; m1_bus.addr = 24'h000070; m1_bus.wmask = 4'h0;
    wait_sreq(ok);
    total++; if (!ok || grant_id !== 1'b0 || s_bus.addr !== 24'h000060) begin
      bad++; $display("FAIL t6_tie0 got=%b/%b/%h exp=1/0/000060", ok, grant_id, s_bus.addr);
    end
    respond(32'h00000066);
    m0_bus.req = 0;
    total++; if (m0_bus.ack !== 1'b1 || m0_bus.rdata !== 32'h00000066) begin bad++; $display("FAIL t6_m0_ack got=%b/%h exp=1/00000066", m0_bus.ack, m0_bus.rdata); end
    @(posedge clk); #1;
    wait_sreq(ok);
    total++; if (!ok || grant_id !== 1'b1 || s_bus.addr !== 24'h000070) begin
      bad++; $display("FAIL t6_next1 got=%b/%b/%h exp=1/1/000070", ok, grant_id, s_bus.addr);
    end
    respond(32'h00000077);
    m1_bus.req = 0;
    total++; if (m1_bus.ack !== 1'b1 || m1_bus.rdata !== 32'h00000077) begin bad++; $display("FAIL t6_m1_ack got=%b/%h exp=1/00000077", m1_bus.ack, m1_bus.rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
